// File: rtl/pc_jump_unit.sv
// Registered next-PC unit: holds the PC, selects sequential/branch/region-jump/register targets,
// and keeps a circular return-address stack that is cross-checked on returns.
module pc_jump_unit #(
    parameter int                ADDR_W      = 32,
    parameter int                REGION_BITS = 4,
    parameter int                RAS_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                            CLK,
    input  logic                            Reset,
    input  logic                            PCWre,
    input  logic [2:0]                      PCSrc,
    input  logic                            BranchTaken,
    input  logic [ADDR_W-1:0]               BranchOffset,
    input  logic [ADDR_W-REGION_BITS-3:0]   JumpIndex,
    input  logic [ADDR_W-1:0]               RegTarget,
    output logic [ADDR_W-1:0]               PC,
    output logic [ADDR_W-1:0]               PC4,
    output logic [ADDR_W-1:0]               RAS_Top,
    output logic                            RAS_Empty,
    output logic                            RAS_Full,
    output logic                            RAS_Miss,
    output logic                            AddrErr
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] SRC_SEQ    = 3'b000;
    localparam logic [2:0] SRC_BRANCH = 3'b001;
    localparam logic [2:0] SRC_JUMP   = 3'b010;
    localparam logic [2:0] SRC_JR     = 3'b011;
    localparam logic [2:0] SRC_CALL   = 3'b100;
    localparam logic [2:0] SRC_RET    = 3'b101;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_miss;
    logic              addr_err;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] region_target;
    logic [ADDR_W-1:0] reg_aligned;
    logic [ADDR_W-1:0] ras_top;
    logic [PTR_W-1:0]  ras_ptr_inc;
    logic              ras_empty;
    logic              ras_full;

    logic [ADDR_W-1:0] pc_next;
    logic              do_push;
    logic              do_pop;
    logic              miss_next;
    logic              addr_err_next;

    assign pc4           = pc + ADDR_W'(4);
    assign branch_target = pc4 + (BranchOffset << 2);
    assign region_target = {pc4[ADDR_W-1 -: REGION_BITS], JumpIndex, 2'b00};
    assign reg_aligned   = {RegTarget[ADDR_W-1:2], 2'b00};
    assign ras_ptr_inc   = ras_ptr + PTR_W'(1);
    assign ras_empty     = (ras_count == '0);
    assign ras_full      = (ras_count == CNT_W'(RAS_DEPTH));
    assign ras_top       = ras_empty ? '0 : ras_mem[ras_ptr];

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        pc_next       = pc;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        miss_next     = 1'b0;
        addr_err_next = 1'b0;
        if (PCWre) begin
            case (PCSrc)
                SRC_SEQ:    pc_next = pc4;
                SRC_BRANCH: pc_next = BranchTaken ? branch_target : pc4;
                SRC_JUMP:   pc_next = region_target;
                SRC_CALL: begin
                    pc_next = region_target;
                    do_push = 1'b1;
                end
                SRC_JR: begin
                    pc_next       = reg_aligned;
                    addr_err_next = (RegTarget[1:0] != 2'b00);
                end
                SRC_RET: begin
                    // The register value is architectural; the RAS only flags a misprediction.
                    pc_next       = reg_aligned;
                    do_pop        = 1'b1;
                    miss_next     = ras_empty || (ras_top != reg_aligned);
                    addr_err_next = (RegTarget[1:0] != 2'b00);
                end
                default: pc_next = pc;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc        <= RESET_PC;
            ras_ptr   <= '0;
            ras_count <= '0;
            ras_miss  <= 1'b0;
            addr_err  <= 1'b0;
            // NOTE: the RAS storage is small and must read as zero after reset, so it is reset explicitly.
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            pc       <= pc_next;
            ras_miss <= miss_next;
            addr_err <= addr_err_next;
            if (do_push) begin
                // When full the incremented pointer lands on the oldest entry and overwrites it.
                ras_mem[ras_ptr_inc] <= pc4;
                ras_ptr              <= ras_ptr_inc;
                if (!ras_full) begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (do_pop && !ras_empty) begin
                ras_ptr   <= ras_ptr - PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
            end
        end
    end

    assign PC        = pc;
    assign PC4       = pc4;
    assign RAS_Top   = ras_top;
    assign RAS_Empty = ras_empty;
    assign RAS_Full  = ras_full;
    assign RAS_Miss  = ras_miss;
    assign AddrErr   = addr_err;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Scoreboard bench for pc_jump_unit: a behavioural PC/RAS model queues expected state per step,
// which is popped and compared one cycle later.
module tb_pc_jump_unit;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 26;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              PCWre;
    logic [2:0]        PCSrc;
    logic              BranchTaken;
    logic [ADDR_W-1:0] BranchOffset;
    logic [IDX_W-1:0]  JumpIndex;
    logic [ADDR_W-1:0] RegTarget;
    logic [ADDR_W-1:0] PC;
    logic [ADDR_W-1:0] PC4;
    logic [ADDR_W-1:0] RAS_Top;
    logic              RAS_Empty;
    logic              RAS_Full;
    logic              RAS_Miss;
    logic              AddrErr;

    pc_jump_unit #(
        .ADDR_W(ADDR_W), .REGION_BITS(4), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
        .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
        .JumpIndex(JumpIndex), .RegTarget(RegTarget),
        .PC(PC), .PC4(PC4), .RAS_Top(RAS_Top), .RAS_Empty(RAS_Empty),
        .RAS_Full(RAS_Full), .RAS_Miss(RAS_Miss), .AddrErr(AddrErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] top;
        logic        empty;
        logic        full;
        logic        miss;
        logic        aerr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_state(input logic miss, input logic aerr);
        exp_t e;
        e.pc    = m_pc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        e.top   = (m_ras.size() != 0) ? m_ras[$] : 32'h0;
        e.miss  = miss;
        e.aerr  = aerr;
        return e;
    endfunction

    task automatic compare_next(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_pc"},    PC,               e.pc);
        check({tag, "_pc4"},   PC4,              e.pc + 32'd4);
        check({tag, "_top"},   RAS_Top,          e.top);
        check({tag, "_empty"}, 32'(RAS_Empty),   32'(e.empty));
        check({tag, "_full"},  32'(RAS_Full),    32'(e.full));
        check({tag, "_miss"},  32'(RAS_Miss),    32'(e.miss));
        check({tag, "_aerr"},  32'(AddrErr),     32'(e.aerr));
    endtask

    task automatic step(input string tag, input logic we, input logic [2:0] src,
                        input logic taken, input logic [31:0] off,
                        input logic [IDX_W-1:0] idx, input logic [31:0] tgt);
        logic [31:0] pc4, aligned, top, region;
        logic        miss, aerr;
        pc4     = m_pc + 32'd4;
        aligned = {tgt[31:2], 2'b00};
        region  = {pc4[31:28], idx, 2'b00};
        top     = (m_ras.size() != 0) ? m_ras[$] : 32'h0;
        miss    = 1'b0;
        aerr    = 1'b0;
        if (we) begin
            case (src)
                3'd0: m_pc = pc4;
                3'd1: m_pc = taken ? pc4 + (off << 2) : pc4;
                3'd2: m_pc = region;
                3'd3: begin
                    m_pc = aligned;
                    aerr = (tgt[1:0] != 2'b00);
                end
                3'd4: begin
                    m_pc = region;
                    m_ras.push_back(pc4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
                3'd5: begin
                    miss = (m_ras.size() == 0) || (top != aligned);
                    aerr = (tgt[1:0] != 2'b00);
                    if (m_ras.size() != 0) void'(m_ras.pop_back());
                    m_pc = aligned;
                end
                default: ;
            endcase
        end
        sb.push_back(model_state(miss, aerr));
        PCWre        = we;
        PCSrc        = src;
        BranchTaken  = taken;
        BranchOffset = off;
        JumpIndex    = idx;
        RegTarget    = tgt;
        @(posedge CLK);
        #1;
        compare_next(tag);
    endtask

    // Asserts Reset between clock edges with a call step pending, checks the async effect before
    // any edge, then releases it after the next edge.
    task automatic async_reset(input string tag);
        PCWre = 1'b1;
        PCSrc = 3'd4;
        #2;
        Reset = 1'b1;
        m_pc  = 32'h0;
        m_ras.delete();
        sb.push_back(model_state(1'b0, 1'b0));
        #1;
        compare_next({tag, "_async"});
        @(posedge CLK);
        #1;
        sb.push_back(model_state(1'b0, 1'b0));
        compare_next({tag, "_held"});
        Reset = 1'b0;
        PCWre = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        PCWre        = 1'b0;
        PCSrc        = 3'd0;
        BranchTaken  = 1'b0;
        BranchOffset = '0;
        JumpIndex    = '0;
        RegTarget    = '0;
        m_pc         = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        sb.push_back(model_state(1'b0, 1'b0));
        compare_next("reset");
        Reset = 1'b0;

        for (int i = 0; i < 3; i++) step("seq", 1, 3'd0, 0, 0, 0, 0);

        step("call_pre_rst", 1, 3'd4, 0, 0, 26'h10, 0);
        async_reset("rst_mid");

        step("jr100", 1, 3'd3, 0, 0, 0, 32'h100);
        step("br_taken", 1, 3'd1, 1, 32'hFFFF_FFFE, 0, 0);
        step("jr100b", 1, 3'd3, 0, 0, 0, 32'h100);
        step("br_ntaken", 1, 3'd1, 0, 32'hFFFF_FFFE, 0, 0);

        step("jr_hi", 1, 3'd3, 0, 0, 0, 32'hF000_0010);
        step("jump", 1, 3'd2, 0, 0, 26'h40, 0);
        step("jr_top", 1, 3'd3, 0, 0, 0, 32'hFFFF_FFFC);
        step("seq_wrap", 1, 3'd0, 0, 0, 0, 0);

        for (int i = 1; i <= 5; i++) begin
            step("jr_callsite", 1, 3'd3, 0, 0, 0, 32'(i * 16));
            step("call", 1, 3'd4, 0, 0, 26'h100, 0);
        end
        step("ret4", 1, 3'd5, 0, 0, 0, 32'h54);
        step("ret3", 1, 3'd5, 0, 0, 0, 32'h44);
        step("ret2", 1, 3'd5, 0, 0, 0, 32'h34);
        step("ret1", 1, 3'd5, 0, 0, 0, 32'h24);
        step("ret_empty", 1, 3'd5, 0, 0, 0, 32'h14);

        step("jr10", 1, 3'd3, 0, 0, 0, 32'h10);
        step("call10", 1, 3'd4, 0, 0, 26'h80, 0);
        step("ret_bad", 1, 3'd5, 0, 0, 0, 32'h99);
        step("pulse_clr", 1, 3'd0, 0, 0, 0, 0);

        step("call_hold", 1, 3'd4, 0, 0, 26'h200, 0);
        for (int i = 0; i < 5; i++) step("we0_call", 0, 3'd4, 0, 0, 26'h3, 0);
        step("rsv110", 1, 3'd6, 1, 32'h10, 26'h5, 32'h3);
        step("rsv111", 1, 3'd7, 1, 32'h10, 26'h5, 32'h3);
        step("jr_misalign", 1, 3'd3, 0, 0, 0, 32'h103);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  src;
            logic [31:0] tgt;
            src = 3'($urandom_range(0, 7));
            tgt = $urandom();
            if (src == 3'd5 && m_ras.size() != 0 && $urandom_range(0, 2) != 0)
                tgt = m_ras[$] | 32'($urandom_range(0, 3));
            step("rand", ($urandom_range(0, 3) != 0), src, 1'($urandom_range(0, 1)),
                 32'($signed(16'($urandom()))), IDX_W'($urandom()), tgt);
        end

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
